// File: rtl/channel_fifo_buffer.sv
// channel_fifo_buffer: DEPTH-entry WIDTH-bit FIFO channel (clk, rst, in_data/write_valid/write_ready in, read_valid/read_ready/out_data out; `define CHANNEL_FIFO_BUFFER_ERR_EN adds sticky err output)
module channel_fifo_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic             read_valid,
  output logic             read_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
  ,
  output logic             err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic wr_en, rd_en;
  always_comb begin
    write_ready = count != CW'(DEPTH);
    read_ready = count != '0;
    wr_en = write_valid & write_ready;
    rd_en = read_valid & read_ready;
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        out_data <= mem[rd_ptr];
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((write_valid & ~write_ready) | (read_valid & ~read_ready)) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_channel_fifo_buffer.sv
// tb_channel_fifo_buffer: randomized and directed checks of channel_fifo_buffer against a queue model
module tb_channel_fifo_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic write_valid = 1'b0;
  logic write_ready;
  logic read_valid = 1'b0;
  logic read_ready;
  logic [WIDTH-1:0] out_data;
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
  logic err;
`endif
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_out = '0;
  logic m_err = 1'b0;
  always #5 clk = ~clk;
  channel_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .write_valid(write_valid),
    .write_ready(write_ready),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .out_data(out_data)
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
    ,
    .err(err)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic wv, input logic [WIDTH-1:0] d, input logic rv);
    bit can_rd, can_wr;
    rst = r;
    write_valid = wv;
    in_data = d;
    read_valid = rv;
    @(posedge clk);
    can_rd = q.size() > 0;
    can_wr = q.size() < DEPTH;
    if (r) begin
      q.delete();
      m_out = '0;
      m_err = 1'b0;
    end else begin
      if ((wv && !can_wr) || (rv && !can_rd)) m_err = 1'b1;
      if (rv && can_rd) m_out = q.pop_front();
      if (wv && can_wr) q.push_back(d);
    end
    #1;
    check("out_data", 64'(out_data), 64'(m_out));
    check("read_ready", 64'(read_ready), 64'(q.size() != 0));
    check("write_ready", 64'(write_ready), 64'(q.size() != DEPTH));
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
    check("err", 64'(err), 64'(m_err));
`endif
    rst = 1'b0;
    write_valid = 1'b0;
    read_valid = 1'b0;
  endtask
  initial begin
    step(1, 0, 0, 0);
    check("reset_out", 64'(out_data), 0);
    check("reset_rr", 64'(read_ready), 0);
    check("reset_wr", 64'(write_ready), 1);
    for (int i = 1; i <= 4; i++) step(0, 1, WIDTH'(i * 10), 0);
    check("full_wr", 64'(write_ready), 0);
    check("full_rr", 64'(read_ready), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1);
      check("seq_out", 64'(out_data), 64'(i * 10));
      step(0, 0, 0, 0);
      check("seq_hold", 64'(out_data), 64'(i * 10));
    end
    for (int i = 1; i <= 4; i++) step(0, 1, WIDTH'(i), 0);
    step(0, 1, 99, 0);
`ifdef CHANNEL_FIFO_BUFFER_ERR_EN
    check("drop_err", 64'(err), 1);
`endif
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1);
      check("drop_out", 64'(out_data), 64'(i));
    end
    check("drop_empty", 64'(read_ready), 0);
    step(1, 0, 0, 0);
    step(0, 1, 7, 1);
    check("empty_both_out", 64'(out_data), 0);
    check("empty_both_rr", 64'(read_ready), 1);
    step(0, 0, 0, 1);
    check("empty_both_rd", 64'(out_data), 7);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, WIDTH'(i), 0);
      step(0, 0, 0, 1);
      check("wrap_out", 64'(out_data), 64'(i));
    end
    step(0, 1, 11, 0);
    step(0, 1, 12, 0);
    step(0, 1, 13, 1);
    check("both_cnt2_out", 64'(out_data), 11);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("both_cnt2_tail", 64'(out_data), 13);
    check("both_cnt2_empty", 64'(read_ready), 0);
    for (int i = 21; i <= 24; i++) step(0, 1, WIDTH'(i), 0);
    step(0, 1, 55, 1);
    check("full_both_out", 64'(out_data), 21);
    check("full_both_wr", 64'(write_ready), 1);
    for (int i = 22; i <= 24; i++) begin
      step(0, 0, 0, 1);
      check("full_both_drain", 64'(out_data), 64'(i));
    end
    check("full_both_empty", 64'(read_ready), 0);
    for (int i = 1; i <= 3; i++) step(0, 1, WIDTH'(i + 30), 0);
    step(0, 0, 0, 1);
    step(1, 1, 77, 1);
    check("mid_rst_rr", 64'(read_ready), 0);
    check("mid_rst_wr", 64'(write_ready), 1);
    check("mid_rst_out", 64'(out_data), 0);
    step(0, 1, 5, 0);
    step(0, 0, 0, 1);
    check("mid_rst_rd", 64'(out_data), 5);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom), WIDTH'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
